// File: rtl/artec_dma_sync_win_if.sv
// Task stream bundle between the task arbiter, the frame synchroniser and the AXI write scheduler.
// The producer drives valid and the task fields; the consumer drives ready.
interface artec_dma_sync_win_if #(
    parameter int IDX_W  = 3,
    parameter int FN_W   = 3,
    parameter int TASK_W = 64
);
    logic              valid;
    logic              ready;
    logic [IDX_W-1:0]  idx;
    logic [FN_W-1:0]   fnum;
    logic              eof;
    logic [TASK_W-1:0] task_dat;

    modport master (output valid, idx, fnum, eof, task_dat, input ready);
    modport slave  (input valid, idx, fnum, eof, task_dat, output ready);
endinterface

// File: rtl/artec_dma_sync_win.sv
// Multi-channel EOF frame synchroniser: tags each outgoing task when its frame is common to all/quorum channels.
// Latency 1 cycle through one output register; backpressure: s.ready = ~m.valid | m.ready.
module artec_dma_sync_win #(
    parameter int CH_NUM = 5,
    parameter int FB_NUM = 8,
    parameter int WIN    = 3,
    parameter int TASK_W = 64,
    parameter int IDX_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    parameter int FN_W   = $clog2(FB_NUM),
    parameter int Q_W    = $clog2(CH_NUM + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic [CH_NUM-1:0]     ch_enable,
    input  logic                  mode,
    input  logic [Q_W-1:0]        quorum,
    artec_dma_sync_win_if.slave   s,
    artec_dma_sync_win_if.master  m,
    output logic                  m_sync,
    output logic [FN_W-1:0]       m_sync_fnum,
    output logic [31:0]           sync_cnt,
    output logic [15:0]           disc_cnt
);
    typedef logic [FB_NUM-1:0] row_t;

    row_t            tbl       [CH_NUM];
    row_t            tbl_nxt   [CH_NUM];
    logic [FN_W-1:0] last_fnum [CH_NUM];
    logic [CH_NUM-1:0] last_vld, last_vld_nxt;

    row_t            hit, set_v, clr_v, eof_oh;
    logic [Q_W-1:0]  en_cnt, cnt_v;
    logic [FN_W-1:0] sync_sel;
    logic            sync_any, accept, eof_acc, consume, disc_hit;

    function automatic row_t win_mask(input logic [FN_W-1:0] f);
        row_t            r;
        logic [FN_W-1:0] p;
        r = '0;
        for (int k = 0; k < WIN; k++) begin
            p    = f - FN_W'(k);
            r[p] = 1'b1;
        end
        return r;
    endfunction

    assign s.ready     = ~m.valid | m.ready;
    assign accept      = s.valid & s.ready;
    assign eof_acc     = accept & s.eof;
    assign m_sync      = m.valid & sync_any & (sync_sel == m.fnum);
    assign m_sync_fnum = sync_sel;
    assign consume     = m.valid & m.ready & m_sync;

    // Sync search over the registered table; the lowest hitting frame number wins.
    always_comb begin
        en_cnt   = '0;
        cnt_v    = '0;
        hit      = '0;
        sync_sel = '0;
        for (int i = 0; i < CH_NUM; i++)
            if (ch_enable[i]) en_cnt = en_cnt + Q_W'(1);
        for (int j = 0; j < FB_NUM; j++) begin
            cnt_v = '0;
            for (int i = 0; i < CH_NUM; i++)
                if (ch_enable[i] && tbl[i][j]) cnt_v = cnt_v + Q_W'(1);
            hit[j] = mode ? ((quorum != '0) && (cnt_v >= quorum))
                          : ((en_cnt != '0) && (cnt_v == en_cnt));
        end
        for (int j = FB_NUM - 1; j >= 0; j--)
            if (hit[j]) sync_sel = FN_W'(j);
        sync_any = |hit;
    end

    always_comb begin
        eof_oh         = '0;
        eof_oh[s.fnum] = 1'b1;
        disc_hit       = 1'b0;
        last_vld_nxt   = last_vld;
        set_v          = '0;
        clr_v          = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            set_v = '0;
            clr_v = consume ? win_mask(sync_sel) : '0;
            if (eof_acc && (s.idx == IDX_W'(i))) begin
                set_v = eof_oh;
                clr_v = clr_v | ~win_mask(s.fnum);
                if (last_vld[i] && (s.fnum != FN_W'(last_fnum[i] + 1'b1))) begin
                    clr_v    = clr_v | ~eof_oh;
                    disc_hit = ch_enable[i];
                end
                last_vld_nxt[i] = 1'b1;
            end
            tbl_nxt[i] = (tbl[i] & ~clr_v) | set_v;
            // A disabled channel holds an empty row and loses its continuity history.
            if (!ch_enable[i]) begin
                tbl_nxt[i]      = '0;
                last_vld_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < CH_NUM; i++) begin
                tbl[i]       <= '0;
                last_fnum[i] <= '0;
            end
            last_vld   <= '0;
            m.valid    <= 1'b0;
            m.idx      <= '0;
            m.fnum     <= '0;
            m.eof      <= 1'b0;
            m.task_dat <= '0;
            sync_cnt   <= '0;
            disc_cnt   <= '0;
        end else if (clear) begin
            for (int i = 0; i < CH_NUM; i++) begin
                tbl[i]       <= '0;
                last_fnum[i] <= '0;
            end
            last_vld   <= '0;
            m.valid    <= 1'b0;
            m.idx      <= '0;
            m.fnum     <= '0;
            m.eof      <= 1'b0;
            m.task_dat <= '0;
            sync_cnt   <= '0;
            disc_cnt   <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                tbl[i] <= tbl_nxt[i];
                if (eof_acc && ch_enable[i] && (s.idx == IDX_W'(i)))
                    last_fnum[i] <= s.fnum;
            end
            last_vld <= last_vld_nxt;
            if (s.ready)
                m.valid <= s.valid;
            if (accept) begin
                m.idx      <= s.idx;
                m.fnum     <= s.fnum;
                m.eof      <= s.eof;
                m.task_dat <= s.task_dat;
            end
            if (consume)
                sync_cnt <= sync_cnt + 32'd1;
            if (disc_hit && (disc_cnt != 16'hFFFF))
                disc_cnt <= disc_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_artec_dma_sync_win.sv
// Directed bench for the frame synchroniser: strict/quorum sync, window, discontinuity, backpressure, reset.
module tb_artec_dma_sync_win;
    logic        clk;
    logic        rstn;
    logic        clear;
    logic [4:0]  ch_enable;
    logic        mode;
    logic [2:0]  quorum;
    logic        m_sync;
    logic [2:0]  m_sync_fnum;
    logic [31:0] sync_cnt;
    logic [15:0] disc_cnt;
    int          n_chk;
    int          n_err;

    artec_dma_sync_win_if #(.IDX_W(3), .FN_W(3), .TASK_W(64)) s_if ();
    artec_dma_sync_win_if #(.IDX_W(3), .FN_W(3), .TASK_W(64)) m_if ();

    artec_dma_sync_win #(.CH_NUM(5), .FB_NUM(8), .WIN(3), .TASK_W(64)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .clear       (clear),
        .ch_enable   (ch_enable),
        .mode        (mode),
        .quorum      (quorum),
        .s           (s_if),
        .m           (m_if),
        .m_sync      (m_sync),
        .m_sync_fnum (m_sync_fnum),
        .sync_cnt    (sync_cnt),
        .disc_cnt    (disc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        s_if.valid = 1'b0;
        clear      = 1'b1;
        step();
        clear      = 1'b0;
    endtask

    task automatic send(input logic [2:0] idx, input logic [2:0] fn, input logic eof);
        s_if.idx      = idx;
        s_if.fnum     = fn;
        s_if.eof      = eof;
        s_if.task_dat = {56'hA5A5_0000_0000_00, 2'b00, idx, fn};
        for (int k = 0; k < 20 && !s_if.ready; k++) step();
        chk("send_rdy", s_if.ready, 1);
        s_if.valid = 1'b1;
        step();
        s_if.valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_err = 0;
        rstn = 1'b0; clear = 1'b0; ch_enable = 5'h1f; mode = 1'b0; quorum = 3'd0;
        s_if.valid = 1'b0; s_if.idx = '0; s_if.fnum = '0; s_if.eof = 1'b0; s_if.task_dat = '0;
        m_if.ready = 1'b1;
        #1;
        chk("rst_m_valid", m_if.valid, 0);
        chk("rst_s_ready", s_if.ready, 1);
        chk("rst_sync_cnt", sync_cnt, 0);
        chk("rst_disc_cnt", disc_cnt, 0);
        chk("rst_m_sync", m_sync, 0);
        #11 rstn = 1'b1;
        step();

        // Strict mode, frame 2 completes on the fifth channel
        for (int c = 0; c < 5; c++) begin
            send(3'(c), 3'd2, 1'b1);
            chk("strict_m_sync", m_sync, (c == 4) ? 1 : 0);
        end
        chk("strict_sync_fnum", m_sync_fnum, 2);
        chk("strict_m_fnum", m_if.fnum, 2);
        step();
        chk("strict_sync_cnt", sync_cnt, 1);
        chk("strict_rows_clr", {dut.tbl[4][2:0], dut.tbl[3][2:0], dut.tbl[2][2:0],
                                dut.tbl[1][2:0], dut.tbl[0][2:0]}, 0);

        // Window of three behind the latest EOF
        do_clear();
        chk("clear_sync_cnt", sync_cnt, 0);
        for (int f = 0; f < 5; f++) send(3'd0, 3'(f), 1'b1);
        chk("win_row0", dut.tbl[0], 8'h1c);
        chk("win_disc", disc_cnt, 0);

        // Discontinuity and wrap-around continuity
        do_clear();
        send(3'd1, 3'd5, 1'b1);
        chk("disc_first", disc_cnt, 0);
        send(3'd1, 3'd3, 1'b1);
        chk("disc_row1", dut.tbl[1], 8'h08);
        chk("disc_cnt1", disc_cnt, 1);
        send(3'd0, 3'd6, 1'b1);
        send(3'd0, 3'd7, 1'b1);
        send(3'd0, 3'd0, 1'b1);
        chk("wrap_row0", dut.tbl[0], 8'hc1);
        chk("wrap_disc", disc_cnt, 1);

        // Quorum of three, then disabling a channel
        do_clear();
        mode = 1'b1; quorum = 3'd3;
        send(3'd0, 3'd1, 1'b1);
        chk("quo_sync_ch0", m_sync, 0);
        send(3'd2, 3'd1, 1'b1);
        chk("quo_sync_ch2", m_sync, 0);
        send(3'd4, 3'd1, 1'b1);
        chk("quo_sync_ch4", m_sync, 1);
        chk("quo_sync_fnum", m_sync_fnum, 1);
        step();
        chk("quo_sync_cnt", sync_cnt, 1);
        send(3'd2, 3'd2, 1'b1);
        chk("quo_row2", dut.tbl[2], 8'h04);
        ch_enable = 5'b11011;
        step();
        chk("dis_row2", dut.tbl[2], 8'h00);
        ch_enable = 5'h1f; mode = 1'b0; quorum = 3'd0;

        // Backpressure on non-EOF tasks
        do_clear();
        m_if.ready = 1'b0;
        s_if.idx = 3'd3; s_if.fnum = 3'd6; s_if.eof = 1'b0; s_if.task_dat = 64'hAAAA;
        s_if.valid = 1'b1;
        step();
        s_if.idx = 3'd1; s_if.fnum = 3'd2; s_if.task_dat = 64'hBBBB;
        for (int k = 0; k < 3; k++) begin
            chk("bp_s_ready", s_if.ready, 0);
            chk("bp_m_valid", m_if.valid, 1);
            chk("bp_m_task", m_if.task_dat, 64'hAAAA);
            chk("bp_m_fnum", m_if.fnum, 6);
            chk("bp_m_idx", m_if.idx, 3);
            step();
        end
        m_if.ready = 1'b1;
        #1;
        chk("bp_release_rdy", s_if.ready, 1);
        step();
        chk("bp_task_b", m_if.task_dat, 64'hBBBB);
        s_if.task_dat = 64'hCCCC;
        step();
        chk("bp_task_c", m_if.task_dat, 64'hCCCC);
        chk("bp_valid_c", m_if.valid, 1);
        s_if.valid = 1'b0;
        step();
        chk("bp_drain", m_if.valid, 0);
        chk("bp_tbl_untouched", {dut.tbl[4], dut.tbl[3], dut.tbl[2], dut.tbl[1], dut.tbl[0]}, 0);

        // Asynchronous reset mid-stream with counters non-zero
        mode = 1'b1; quorum = 3'd1;
        send(3'd1, 3'd5, 1'b1);
        chk("q1_sync", m_sync, 1);
        send(3'd1, 3'd0, 1'b1);
        chk("q1_sync_wrap", m_sync, 1);
        send(3'd2, 3'd4, 1'b0);
        m_if.ready = 1'b0;
        step();
        chk("pre_rst_valid", m_if.valid, 1);
        chk("pre_rst_sync_cnt", sync_cnt, 2);
        chk("pre_rst_disc", disc_cnt, 1);
        #3 rstn = 1'b0;
        #1;
        chk("arst_m_valid", m_if.valid, 0);
        chk("arst_m_task", m_if.task_dat, 0);
        chk("arst_m_fnum", m_if.fnum, 0);
        chk("arst_m_sync", m_sync, 0);
        chk("arst_sync_cnt", sync_cnt, 0);
        chk("arst_disc_cnt", disc_cnt, 0);
        chk("arst_row1", dut.tbl[1], 0);
        @(negedge clk);
        rstn = 1'b1;
        mode = 1'b0; quorum = 3'd0;
        step();
        chk("post_rst_s_ready", s_if.ready, 1);
        chk("post_rst_m_valid", m_if.valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
